serial_gate_reducer: RTL and testbench
======================================

# serial_gate_reducer

Sequential stage that consumes a packet of words on a valid/ready stream. It folds the words bitwise with OR, AND or XOR, and each per-bit gate is built only from 2:1 `mux` instances and constants. It presents one result word per packet on an output valid/ready stream. It sits downstream of the combinational mux-built gates: it reuses the same mux construction per bit and adds accumulation, packet framing and handshaking.

## Interface
- `W`, 8: data word width.
- `CNT_W`, 8: width of the beat counter (only used with the macro below).
- `clk`  input  1  the block's only clock; all state updates on its rising edge.
- `rst_n`  input  1  reset: synchronous, active-low. Sampled on the rising edge of `clk`.
- `op`  input  2  operation code: 00 OR, 01 AND, 10 XOR, 11 reserved (treated as OR).
- `in_valid`  input  1  input beat valid.
- `in_ready`  output  1  block can accept a beat.
- `in_data`  input  W  input word.
- `in_last`  input  1  marks the final beat of a packet.
- `out_valid`  output  1  result word valid.
- `out_ready`  input  1  downstream accepts the result.
- `out_data`  output  W  reduced result.
- `out_count`  output  CNT_W  beats in the packet (present only when `SERIAL_GATE_REDUCER_COUNT_EN` is defined).

## Operation
- A beat transfers when `in_valid && in_ready`. A result transfers when `out_valid && out_ready`.
- The FSM has three states: IDLE, ACC, HOLD. Reset state is IDLE.
- **IDLE**
  - `in_ready`=1.
  - On a transfer: accumulator <= `in_data`; `op` is latched.
  - If `in_last` is set, go to HOLD; otherwise go to ACC.
- **ACC**
  - `in_ready`=1.
  - On a transfer: accumulator <= latched_op(accumulator, `in_data`), applied bitwise.
  - If `in_last` is set, go to HOLD.
  - No transfer: accumulator holds.
- **HOLD**
  - `in_ready`=0, `out_valid`=1, `out_data`=accumulator.
  - When `out_ready`=1, go to IDLE.
- `op` is sampled only on the first beat of a packet. Changes to `op` mid-packet are ignored.
- Per-bit gates use mux instances only:
  - OR = mux(d0=a, d1=1, sel=b)
  - AND = mux(d0=0, d1=a, sel=b)
  - XOR = mux(d0=a, d1=~a, sel=b)
  - A final 3:1 selection picks the result, also built from muxes.
- Values on `in_data`, `in_last` and `op` are don't-care when `in_valid`=0.

## Timing
- Reset values: `in_ready`=0 during the reset cycle and 1 on the first cycle after reset release; `out_valid`=0; `out_data`=0; `out_count`=0; accumulator=0.
- Latency: `out_valid` rises on the cycle after the `in_last` beat transfers.
- The block sustains one beat per cycle while a packet is in flight.
- There is one mandatory bubble between packets: `in_ready` is 0 throughout HOLD, including the cycle in which the result transfers.
- Backpressure: while `out_ready`=0, `out_data` and `out_count` stay stable and `out_valid` stays 1.
- `out_valid` never depends combinationally on `out_ready`. `in_ready` depends only on state.
- Reset mid-packet or during HOLD: the partial or pending result is discarded, and the FSM returns to IDLE on the next edge.
- A single-beat packet (`in_last` set on the first beat) gives `out_data` = `in_data` unchanged, for any op.

## Configuration
- `SERIAL_GATE_REDUCER_COUNT_EN` defined:
  - `out_count` port exists.
  - Counter is set to 1 on the first beat and incremented on each further beat.
  - Counter saturates at 2^CNT_W−1 and holds in HOLD.
- Not defined: port and counter are absent. All other behaviour is identical.

## Structure
- Package `serial_gate_reducer_pkg`:
  - op enum: OP_OR=2'b00, OP_AND=2'b01, OP_XOR=2'b10, OP_RSVD=2'b11.
  - FSM state enum: ST_IDLE, ST_ACC, ST_HOLD.
- Sub-module `gate_mux_slice`:
  - Inputs a, b, op; output y.
  - Contains only mux instances and constants.
  - Instantiated W times by generate.
- The top level holds the FSM, accumulator register, op latch and optional counter.

## Test plan
- OR packet 0x01, 0x10, 0x80 (last), `out_ready`=1 -> `out_data`=0x91 one cycle after the last beat; `out_count`=3.
- AND packet 0xFF, 0x0F, 0x3C; `op` switched to XOR on beat 2 -> `out_data`=0x0C (latched op is used).
- XOR packet 0xAA, 0xFF, op=11 on the next packet 0x01, 0x02 -> results 0x55 then 0x03 (reserved op acts as OR).
- Backpressure: `out_ready`=0 for 3 cycles in HOLD -> `out_valid`=1, `out_data` stable, `in_ready`=0; the result transfers on the 4th cycle, and `in_ready`=1 on the following cycle.
- Reset mid-packet: 2 beats of OR, then `rst_n`=0 for one cycle -> `out_valid`=0; the next packet 0x0F (last) yields 0x0F with no carry-over.
- With macro and CNT_W=2: 5-beat packet -> `out_count`=3 (saturated).

Source files
------------

// File: rtl/serial_gate_reducer_pkg.sv
// -----------------------------------------------------------------------------
// serial_gate_reducer_pkg
// Shared types for the serial gate reducer: the operation code carried on the
// input stream and the three-state framing FSM encoding.
// Optional feature macro used elsewhere: SERIAL_GATE_REDUCER_COUNT_EN
// -----------------------------------------------------------------------------
package serial_gate_reducer_pkg;

    // Operation codes; the reserved code behaves as OR inside the gate slice.
    typedef enum logic [1:0] {
        OP_OR   = 2'b00,
        OP_AND  = 2'b01,
        OP_XOR  = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    // Packet framing states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ACC  = 2'b01,
        ST_HOLD = 2'b10
    } state_e;

    // True when a beat counter is at its saturation value.
    function automatic logic cnt_is_max(input logic [31:0] cnt, input int unsigned cnt_w);
        logic [31:0] max_v;
        max_v = (cnt_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << cnt_w) - 32'd1);
        return (cnt == max_v);
    endfunction

endpackage

// File: rtl/serial_gate_reducer_if.sv
// -----------------------------------------------------------------------------
// serial_gate_reducer_if
// Bundles the input beat stream (op, in_valid, in_ready, in_data, in_last) and
// the result stream (out_valid, out_ready, out_data[, out_count]).
//   master : the environment side (drives beats, accepts results)
//   slave  : the reducer side
// out_count exists only when SERIAL_GATE_REDUCER_COUNT_EN is defined.
// -----------------------------------------------------------------------------
interface serial_gate_reducer_if #(
    parameter int W     = 8,
    parameter int CNT_W = 8
) ();
    logic [1:0]     op;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_data;
    logic           in_last;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
`ifdef SERIAL_GATE_REDUCER_COUNT_EN
    logic [CNT_W-1:0] out_count;
`endif

    modport master (
        output op, in_valid, in_data, in_last, out_ready,
`ifdef SERIAL_GATE_REDUCER_COUNT_EN
        input  out_count,
`endif
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  op, in_valid, in_data, in_last, out_ready,
`ifdef SERIAL_GATE_REDUCER_COUNT_EN
        output out_count,
`endif
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/serial_gate_reducer_slice.sv
// -----------------------------------------------------------------------------
// mux / gate_mux_slice
// mux            : 2:1 multiplexer, y = sel ? d1 : d0.
// gate_mux_slice : one bit of the reducer datapath. Computes OR, AND and XOR of
//                  a and b purely from mux instances and constants, then picks
//                  one with a mux tree driven by op.
//   a  : accumulator bit      b : incoming data bit
//   op : 00 OR, 01 AND, 10 XOR, 11 OR        y : selected gate output
// -----------------------------------------------------------------------------
module mux (
    input  logic d0,
    input  logic d1,
    input  logic sel,
    output logic y
);
    assign y = sel ? d1 : d0;
endmodule

module gate_mux_slice (
    input  logic       a,
    input  logic       b,
    input  logic [1:0] op,
    output logic       y
);
    logic or_y;
    logic and_y;
    logic not_a;
    logic xor_y;
    logic sel_lo;
    logic sel_hi;

    mux u_or  (.d0(a),    .d1(1'b1),  .sel(b),     .y(or_y));
    mux u_and (.d0(1'b0), .d1(a),     .sel(b),     .y(and_y));
    // Inverter built from a mux so the slice stays mux-only.
    mux u_not (.d0(1'b1), .d1(1'b0),  .sel(a),     .y(not_a));
    mux u_xor (.d0(a),    .d1(not_a), .sel(b),     .y(xor_y));

    // 3:1 pick: op[0] splits OR/AND and XOR/OR(reserved), op[1] picks the pair.
    mux u_lo  (.d0(or_y),   .d1(and_y),  .sel(op[0]), .y(sel_lo));
    mux u_hi  (.d0(xor_y),  .d1(or_y),   .sel(op[0]), .y(sel_hi));
    mux u_out (.d0(sel_lo), .d1(sel_hi), .sel(op[1]), .y(y));
endmodule

// File: rtl/serial_gate_reducer.sv
// -----------------------------------------------------------------------------
// serial_gate_reducer
// Folds every beat of a packet into one word with OR, AND or XOR (op taken
// from the first beat only) and returns one result per packet.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : serial_gate_reducer_if.slave (input beats, result stream)
// Optional feature: define SERIAL_GATE_REDUCER_COUNT_EN to add a saturating
// beat counter presented on bus.out_count.
// Flow: IDLE takes the first beat, ACC folds further beats, HOLD presents the
// result and refuses input until it has been accepted.
// -----------------------------------------------------------------------------
module serial_gate_reducer
    import serial_gate_reducer_pkg::*;
#(
    parameter int W     = 8,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    serial_gate_reducer_if.slave   bus
);

    state_e         state_q;
    state_e         state_d;
    logic [W-1:0]   acc_q;
    logic [W-1:0]   acc_d;
    op_e            op_q;
    op_e            op_d;
    logic           in_ready_q;
    logic           in_ready_d;
    logic           out_valid_q;
    logic           out_valid_d;
    logic [W-1:0]   gate_y;
    logic           beat_fire;
`ifdef SERIAL_GATE_REDUCER_COUNT_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
`endif

    // One mux-built gate slice per data bit, folding the accumulator with the beat.
    for (genvar gi = 0; gi < W; gi++) begin : g_slice
        gate_mux_slice u_slice (
            .a  (acc_q[gi]),
            .b  (bus.in_data[gi]),
            .op (op_q),
            .y  (gate_y[gi])
        );
    end

    // in_ready_q is registered, so it is 0 through the reset cycle as required.
    assign beat_fire = bus.in_valid && in_ready_q;

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        op_d    = op_q;
`ifdef SERIAL_GATE_REDUCER_COUNT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (beat_fire) begin
                    acc_d = bus.in_data;
                    op_d  = op_e'(bus.op);
`ifdef SERIAL_GATE_REDUCER_COUNT_EN
                    cnt_d = CNT_W'(1);
`endif
                    state_d = bus.in_last ? ST_HOLD : ST_ACC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACC: begin
                if (beat_fire) begin
                    acc_d = gate_y;
`ifdef SERIAL_GATE_REDUCER_COUNT_EN
                    if (cnt_is_max(32'(cnt_q), CNT_W)) begin
                        cnt_d = cnt_q;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
`endif
                    state_d = bus.in_last ? ST_HOLD : ST_ACC;
                end else begin
                    state_d = ST_ACC;
                end
            end
            ST_HOLD: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Handshake outputs follow the next state so they are valid right after the edge.
        in_ready_d  = (state_d != ST_HOLD);
        out_valid_d = (state_d == ST_HOLD);
    end

    // FSM, accumulator, op latch, counter and handshake output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= {W{1'b0}};
            op_q        <= OP_OR;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef SERIAL_GATE_REDUCER_COUNT_EN
            cnt_q       <= {CNT_W{1'b0}};
`endif
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            op_q        <= op_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef SERIAL_GATE_REDUCER_COUNT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = acc_q;
`ifdef SERIAL_GATE_REDUCER_COUNT_EN
    assign bus.out_count = cnt_q;
`endif

endmodule

// File: tb/tb_serial_gate_reducer.sv
// -----------------------------------------------------------------------------
// tb_serial_gate_reducer
// Scoreboard bench: the driver pushes the expected word (and beat count) for a
// packet when its last beat is accepted; a negedge monitor pops and compares
// whenever a result transfers. Directed packets cover the listed scenarios,
// then randomized packets with random ops, gaps and backpressure follow.
// -----------------------------------------------------------------------------
module tb_serial_gate_reducer;
    import serial_gate_reducer_pkg::*;

    localparam int W = 8;
`ifdef SERIAL_GATE_REDUCER_COUNT_EN
    localparam int CW = 2;
`else
    localparam int CW = 8;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_gate_reducer_if #(.W(W), .CNT_W(CW)) bus ();

    serial_gate_reducer #(.W(W), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] data;
        int         count;
    } exp_t;

    exp_t       exp_q[$];
    int         errors = 0;
    int         checks = 0;
    int         or_mode = 0;   // 0: out_ready=1, 1: random, 2: out_ready=0
    logic [7:0] beats[$];
    logic [1:0] bops[$];
    bit         blast[$];

    task automatic check(input bit ok, input string name, input longint act, input longint expv);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    // Reference: fold a whole packet with the op of its first beat.
    function automatic logic [7:0] ref_fold(input logic [1:0] op, input logic [7:0] w[$]);
        logic [7:0] r;
        r = w[0];
        for (int i = 1; i < w.size(); i++) begin
            case (op)
                2'b01:   r = r & w[i];
                2'b10:   r = r ^ w[i];
                default: r = r | w[i];
            endcase
        end
        return r;
    endfunction

    function automatic int sat_count(input int n);
        int mx;
        mx = (1 << CW) - 1;
        return (n > mx) ? mx : n;
    endfunction

    // out_ready driver, updated just after each rising edge.
    always @(posedge clk) begin
        #1;
        case (or_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = ($urandom_range(0, 3) != 0);
            default: bus.out_ready = 1'b0;
        endcase
    end

    // Send the packet held in beats/bops/blast; expected results pushed on last beat.
    task automatic send_pkt(input bit gaps);
        logic [7:0] got[$];
        logic [1:0] fop;
        int guard;
        fop = 2'b00;
        @(posedge clk); #1;
        for (int i = 0; i < beats.size(); i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = beats[i];
            bus.in_last  = blast[i];
            bus.op       = bops[i];
            guard = 0;
            @(negedge clk);
            while (!bus.in_ready && guard < 100) begin
                guard++;
                @(negedge clk);
            end
            if (!bus.in_ready) begin
                check(1'b0, "in_ready_timeout", 0, 1);
                bus.in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            if (got.size() == 0) fop = bops[i];
            got.push_back(beats[i]);
            if (blast[i]) begin
                exp_q.push_back('{ref_fold(fop, got), got.size()});
                got.delete();
            end
            if (gaps && $urandom_range(0, 3) == 0) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'($urandom);
                bus.in_last  = 1'($urandom);
                bus.op       = 2'($urandom);
                @(posedge clk); #1;
            end
        end
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        bus.in_last  = 1'($urandom);
        bus.op       = 2'($urandom);
    endtask

    task automatic load3(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                         input logic [1:0] o0, input logic [1:0] o1, input int n, input bit last);
        beats.delete(); bops.delete(); blast.delete();
        beats.push_back(d0); bops.push_back(o0); blast.push_back(last && n == 1);
        if (n > 1) begin beats.push_back(d1); bops.push_back(o1); blast.push_back(last && n == 2); end
        if (n > 2) begin beats.push_back(d2); bops.push_back(o1); blast.push_back(last && n == 3); end
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || bus.out_valid) && guard < 300) begin
            guard++;
            @(negedge clk);
        end
        check(exp_q.size() == 0 && !bus.out_valid, "drain_timeout", exp_q.size(), 0);
    endtask

    // Monitor: scoreboard pop on each result transfer plus HOLD-phase properties.
    exp_t       mon_e;
    bit         prev_bp = 1'b0;
    logic [7:0] prev_data;
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid) begin
                check(!bus.in_ready, "in_ready_in_hold", bus.in_ready, 0);
                if (prev_bp) check(bus.out_data == prev_data, "bp_data_stable", bus.out_data, prev_data);
                if (bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        check(1'b0, "unexpected_result", bus.out_data, 0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check(bus.out_data == mon_e.data, "result_data", bus.out_data, mon_e.data);
`ifdef SERIAL_GATE_REDUCER_COUNT_EN
                        check(int'(bus.out_count) == sat_count(mon_e.count), "result_count",
                              bus.out_count, sat_count(mon_e.count));
`endif
                    end
                end
            end
            prev_bp   = bus.out_valid && !bus.out_ready;
            prev_data = bus.out_data;
        end else begin
            prev_bp = 1'b0;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_last  = 1'b0;
        bus.op       = 2'b00;
        rst_n        = 1'b0;
        or_mode      = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check(bus.in_ready == 1'b0, "rst_in_ready", bus.in_ready, 0);
        check(bus.out_valid == 1'b0, "rst_out_valid", bus.out_valid, 0);
        check(bus.out_data == 8'h00, "rst_out_data", bus.out_data, 0);
`ifdef SERIAL_GATE_REDUCER_COUNT_EN
        check(bus.out_count == 2'd0, "rst_out_count", bus.out_count, 0);
`endif
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check(bus.in_ready == 1'b0, "release_in_ready_before_edge", bus.in_ready, 0);
        @(negedge clk);
        check(bus.in_ready == 1'b1, "release_in_ready", bus.in_ready, 1);

        // OR packet: 01 | 10 | 80 = 91, result one cycle after the last beat.
        load3(8'h01, 8'h10, 8'h80, 2'b00, 2'b00, 3, 1'b1);
        send_pkt(1'b0);
        @(negedge clk);
        check(bus.out_valid == 1'b1, "or_latency", bus.out_valid, 1);
        check(bus.out_data == 8'h91, "or_value", bus.out_data, 8'h91);
`ifdef SERIAL_GATE_REDUCER_COUNT_EN
        check(bus.out_count == 2'd3, "or_count", bus.out_count, 3);
`endif
        wait_idle();

        // AND packet with op switched to XOR mid-packet: latched AND gives 0C.
        load3(8'hFF, 8'h0F, 8'h3C, 2'b01, 2'b10, 3, 1'b1);
        send_pkt(1'b0);
        @(negedge clk);
        check(bus.out_data == 8'h0C, "and_latched_op", bus.out_data, 8'h0C);
        wait_idle();

        // XOR AA^FF = 55, then reserved op on 01,02 acts as OR = 03.
        load3(8'hAA, 8'hFF, 8'h00, 2'b10, 2'b10, 2, 1'b1);
        send_pkt(1'b0);
        @(negedge clk);
        check(bus.out_data == 8'h55, "xor_value", bus.out_data, 8'h55);
        wait_idle();
        load3(8'h01, 8'h02, 8'h00, 2'b11, 2'b11, 2, 1'b1);
        send_pkt(1'b0);
        @(negedge clk);
        check(bus.out_data == 8'h03, "rsvd_as_or", bus.out_data, 8'h03);
        wait_idle();

        // Single-beat packet passes data unchanged even with AND.
        load3(8'hC3, 8'h00, 8'h00, 2'b01, 2'b01, 1, 1'b1);
        send_pkt(1'b0);
        @(negedge clk);
        check(bus.out_data == 8'hC3, "single_beat", bus.out_data, 8'hC3);
        wait_idle();

        // Backpressure: three HOLD cycles with out_ready=0, accepted on the fourth.
        or_mode = 2;
        load3(8'h5A, 8'h33, 8'h00, 2'b10, 2'b10, 2, 1'b1);
        send_pkt(1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check(bus.out_valid == 1'b1, "bp_out_valid", bus.out_valid, 1);
            check(bus.in_ready == 1'b0, "bp_in_ready", bus.in_ready, 0);
            check(bus.out_data == 8'h69, "bp_out_data", bus.out_data, 8'h69);
        end
        or_mode = 0;
        @(negedge clk);
        @(negedge clk);
        check(bus.out_valid == 1'b0, "bp_released_valid", bus.out_valid, 0);
        check(bus.in_ready == 1'b1, "bp_released_in_ready", bus.in_ready, 1);
        wait_idle();

        // Reset mid-packet discards the partial result.
        load3(8'hF0, 8'h0C, 8'h00, 2'b00, 2'b00, 2, 1'b0);
        send_pkt(1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check(bus.out_valid == 1'b0, "midrst_out_valid", bus.out_valid, 0);
        check(bus.in_ready == 1'b0, "midrst_in_ready", bus.in_ready, 0);
        load3(8'h0F, 8'h00, 8'h00, 2'($urandom), 2'b00, 1, 1'b1);
        send_pkt(1'b0);
        @(negedge clk);
        check(bus.out_data == 8'h0F, "midrst_no_carry", bus.out_data, 8'h0F);
        wait_idle();

`ifdef SERIAL_GATE_REDUCER_COUNT_EN
        // Five beats saturate a 2-bit counter at 3.
        beats.delete(); bops.delete(); blast.delete();
        for (int i = 0; i < 5; i++) begin
            beats.push_back(8'(1 << i)); bops.push_back(2'b00); blast.push_back(i == 4);
        end
        send_pkt(1'b0);
        @(negedge clk);
        check(bus.out_count == 2'd3, "count_saturate", bus.out_count, 3);
        check(bus.out_data == 8'h1F, "count_pkt_data", bus.out_data, 8'h1F);
        wait_idle();
`endif

        // Randomized packets with random ops, gaps and backpressure.
        or_mode = 1;
        for (int p = 0; p < 40; p++) begin
            n = $urandom_range(1, 6);
            beats.delete(); bops.delete(); blast.delete();
            for (int i = 0; i < n; i++) begin
                beats.push_back(8'($urandom));
                bops.push_back(2'($urandom));
                blast.push_back(i == n - 1);
            end
            send_pkt(1'b1);
        end
        @(negedge clk);
        or_mode = 0;
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
